control_unit: RTL and testbench

Hardwired microsequencer for the single-bus CPU. Decodes the 5-bit opcode from `CPU_datapath` and steps T0–T7, driving every datapath control strobe a testbench drives by hand today. Sits beside `CPU_datapath`: consumes `opcode`/`conFF`, produces the control word, runs one instruction after another until halt.

---
 rtl/cpu_ctrl_pkg.sv | 128 ++++++++++++
 rtl/ctrl_decode.sv | 137 +++++++++++++
 rtl/control_unit.sv | 72 +++++++
 tb/tb_control_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Brief    : Opcodes, sequencer states and control-word bit indices shared
//            by control_unit and the CPU_datapath benches.
// Revision : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    localparam int C_CTRL_W = 30;

    localparam logic [4:0] C_OP_LD   = 5'b00000;
    localparam logic [4:0] C_OP_LDI  = 5'b00001;
    localparam logic [4:0] C_OP_ST   = 5'b00010;
    localparam logic [4:0] C_OP_ADD  = 5'b00011;
    localparam logic [4:0] C_OP_SUB  = 5'b00100;
    localparam logic [4:0] C_OP_AND  = 5'b00101;
    localparam logic [4:0] C_OP_OR   = 5'b00110;
    localparam logic [4:0] C_OP_ROR  = 5'b00111;
    localparam logic [4:0] C_OP_ROL  = 5'b01000;
    localparam logic [4:0] C_OP_SHR  = 5'b01001;
    localparam logic [4:0] C_OP_SHRA = 5'b01010;
    localparam logic [4:0] C_OP_SHL  = 5'b01011;
    localparam logic [4:0] C_OP_ADDI = 5'b01100;
    localparam logic [4:0] C_OP_ANDI = 5'b01101;
    localparam logic [4:0] C_OP_ORI  = 5'b01110;
    localparam logic [4:0] C_OP_DIV  = 5'b01111;
    localparam logic [4:0] C_OP_MUL  = 5'b10000;
    localparam logic [4:0] C_OP_NEG  = 5'b10001;
    localparam logic [4:0] C_OP_BR   = 5'b10010;
    localparam logic [4:0] C_OP_NOT  = 5'b10011;
    localparam logic [4:0] C_OP_JR   = 5'b10100;
    localparam logic [4:0] C_OP_IN   = 5'b10101;
    localparam logic [4:0] C_OP_OUT  = 5'b10110;
    localparam logic [4:0] C_OP_MFLO = 5'b10111;
    localparam logic [4:0] C_OP_MFHI = 5'b11000;
    localparam logic [4:0] C_OP_NOP  = 5'b11001;
    localparam logic [4:0] C_OP_HALT = 5'b11010;

    localparam int C_PCOUT         = 0;
    localparam int C_ZHIGHOUT      = 1;
    localparam int C_ZLOWOUT       = 2;
    localparam int C_MDROUT        = 3;
    localparam int C_HIOUT         = 4;
    localparam int C_LOOUT         = 5;
    localparam int C_INPORTOUT     = 6;
    localparam int C_COUT          = 7;
    localparam int C_YOUT          = 8;
    localparam int C_MARIN         = 9;
    localparam int C_MDRIN         = 10;
    localparam int C_PCIN          = 11;
    localparam int C_IRIN          = 12;
    localparam int C_YIN           = 13;
    localparam int C_ZIN           = 14;
    localparam int C_HIIN          = 15;
    localparam int C_LOIN          = 16;
    localparam int C_INCPC         = 17;
    localparam int C_READ          = 18;
    localparam int C_RAMRD         = 19;
    localparam int C_RAMIN         = 20;
    localparam int C_GRA           = 21;
    localparam int C_GRB           = 22;
    localparam int C_GRC           = 23;
    localparam int C_BAOUT         = 24;
    localparam int C_ROUT_IN       = 25;
    localparam int C_R_ENABLEIN    = 26;
    localparam int C_ENABLECON     = 27;
    localparam int C_ENABLEOUTPORT = 28;
    localparam int C_ENABLEINPORT  = 29;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    // Instructions sharing an identical execute sequence collapse to one class.
    typedef enum logic [3:0] {
        CL_ALU, CL_IMM, CL_MULDIV, CL_NEGNOT, CL_LDI, CL_LD, CL_ST, CL_BR,
        CL_JR, CL_MFHI, CL_MFLO, CL_IN, CL_OUT, CL_NOP, CL_HALT
    } op_class_t;

    function automatic op_class_t op_class(input logic [4:0] op);
        op_class_t cl;
        cl = CL_NOP;
        case (op)
            C_OP_ADD, C_OP_SUB, C_OP_AND, C_OP_OR, C_OP_ROR,
            C_OP_ROL, C_OP_SHR, C_OP_SHRA, C_OP_SHL:  cl = CL_ALU;
            C_OP_ADDI, C_OP_ANDI, C_OP_ORI:          cl = CL_IMM;
            C_OP_MUL, C_OP_DIV:                      cl = CL_MULDIV;
            C_OP_NEG, C_OP_NOT:                      cl = CL_NEGNOT;
            C_OP_LDI:                                cl = CL_LDI;
            C_OP_LD:                                 cl = CL_LD;
            C_OP_ST:                                 cl = CL_ST;
            C_OP_BR:                                 cl = CL_BR;
            C_OP_JR:                                 cl = CL_JR;
            C_OP_MFHI:                               cl = CL_MFHI;
            C_OP_MFLO:                               cl = CL_MFLO;
            C_OP_IN:                                 cl = CL_IN;
            C_OP_OUT:                                cl = CL_OUT;
            C_OP_HALT:                               cl = CL_HALT;
            default:                                 cl = CL_NOP;
        endcase
        return cl;
    endfunction

    function automatic state_t last_step(input op_class_t cl);
        state_t st;
        case (cl)
            CL_ALU, CL_IMM, CL_LDI:                 st = ST_T5;
            CL_MULDIV, CL_BR:                       st = ST_T6;
            CL_NEGNOT:                              st = ST_T4;
            CL_LD, CL_ST:                           st = ST_T7;
            CL_JR, CL_MFHI, CL_MFLO, CL_IN, CL_OUT: st = ST_T3;
            default:                                st = ST_T2;
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode
// Brief    : Combinational control-word decode from sequencer step, opcode
//            and branch condition.
// Revision : 1.0  initial release
// ============================================================================
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t                state,
    input  logic [4:0]            opcode,
    input  logic                  conFF,
    output logic [C_CTRL_W-1:0]   ctrl
);

    op_class_t w_cl;
    assign w_cl = op_class(opcode);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_T0: begin
                ctrl[C_PCOUT] = 1'b1; ctrl[C_MARIN] = 1'b1; ctrl[C_INCPC] = 1'b1;
            end
            ST_T1: begin
                ctrl[C_RAMRD] = 1'b1; ctrl[C_READ] = 1'b1; ctrl[C_MDRIN] = 1'b1;
            end
            ST_T2: begin
                ctrl[C_MDROUT] = 1'b1; ctrl[C_IRIN] = 1'b1;
            end
            ST_T3: begin
                case (w_cl)
                    CL_ALU, CL_IMM: begin
                        ctrl[C_GRB] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_YIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl[C_GRA] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_YIN] = 1'b1;
                    end
                    CL_NEGNOT: begin
                        ctrl[C_GRB] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_ZIN] = 1'b1;
                    end
                    // Immediate-address forms read the base via BAout so R0 reads as zero.
                    CL_LDI, CL_LD, CL_ST: begin
                        ctrl[C_GRB] = 1'b1; ctrl[C_BAOUT] = 1'b1; ctrl[C_YIN] = 1'b1;
                    end
                    CL_BR: begin
                        ctrl[C_GRA] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_ENABLECON] = 1'b1;
                    end
                    CL_JR: begin
                        ctrl[C_GRA] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_PCIN] = 1'b1;
                    end
                    CL_MFHI: begin
                        ctrl[C_GRA] = 1'b1; ctrl[C_R_ENABLEIN] = 1'b1; ctrl[C_HIOUT] = 1'b1;
                    end
                    CL_MFLO: begin
                        ctrl[C_GRA] = 1'b1; ctrl[C_R_ENABLEIN] = 1'b1; ctrl[C_LOOUT] = 1'b1;
                    end
                    CL_IN: begin
                        ctrl[C_GRA] = 1'b1; ctrl[C_R_ENABLEIN] = 1'b1; ctrl[C_INPORTOUT] = 1'b1;
                    end
                    CL_OUT: begin
                        ctrl[C_GRA] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_ENABLEOUTPORT] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_cl)
                    CL_ALU: begin
                        ctrl[C_GRC] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_ZIN] = 1'b1;
                    end
                    CL_IMM, CL_LDI, CL_LD, CL_ST: begin
                        ctrl[C_COUT] = 1'b1; ctrl[C_ZIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl[C_GRB] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_ZIN] = 1'b1;
                    end
                    CL_NEGNOT: begin
                        ctrl[C_ZLOWOUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_ENABLEIN] = 1'b1;
                    end
                    CL_BR: begin
                        ctrl[C_PCOUT] = 1'b1; ctrl[C_YIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_cl)
                    CL_ALU, CL_IMM, CL_LDI: begin
                        ctrl[C_ZLOWOUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_ENABLEIN] = 1'b1;
                    end
                    CL_MULDIV: begin
                        ctrl[C_ZLOWOUT] = 1'b1; ctrl[C_LOIN] = 1'b1;
                    end
                    CL_LD, CL_ST: begin
                        ctrl[C_ZLOWOUT] = 1'b1; ctrl[C_MARIN] = 1'b1;
                    end
                    CL_BR: begin
                        ctrl[C_COUT] = 1'b1; ctrl[C_ZIN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (w_cl)
                    CL_MULDIV: begin
                        ctrl[C_ZHIGHOUT] = 1'b1; ctrl[C_HIIN] = 1'b1;
                    end
                    CL_LD: begin
                        ctrl[C_RAMRD] = 1'b1; ctrl[C_READ] = 1'b1; ctrl[C_MDRIN] = 1'b1;
                    end
                    // Store loads MDR from the bus, so Read stays low to select the bus path.
                    CL_ST: begin
                        ctrl[C_GRA] = 1'b1; ctrl[C_ROUT_IN] = 1'b1; ctrl[C_MDRIN] = 1'b1;
                    end
                    CL_BR: begin
                        ctrl[C_ZLOWOUT] = 1'b1; ctrl[C_PCIN] = conFF;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (w_cl)
                    CL_LD: begin
                        ctrl[C_MDROUT] = 1'b1; ctrl[C_GRA] = 1'b1; ctrl[C_R_ENABLEIN] = 1'b1;
                    end
                    CL_ST: ctrl[C_RAMIN] = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Hardwired T0-T7 microsequencer for the single-bus CPU.
//            Optional macro CU_STOP_EN adds a 'stop' input that diverts the
//            end of the current instruction into HALT.
// Revision : 1.0  initial release
// ============================================================================
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            opcode,
    input  logic                  conFF,
`ifdef CU_STOP_EN
    input  logic                  stop,
`endif
    output logic [C_CTRL_W-1:0]   ctrl,
    output logic                  run,
    output logic [3:0]            step
);

    state_t    state_q;
    state_t    state_d;
    op_class_t w_cl;
    logic      w_stop;

`ifdef CU_STOP_EN
    assign w_stop = stop;
`else
    assign w_stop = 1'b0;
`endif

    assign w_cl = op_class(opcode);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: begin
                // A halt opcode simply ends its (fetch-only) instruction in HALT.
                if (state_q == last_step(w_cl)) begin
                    state_d = (w_cl == CL_HALT || w_stop) ? ST_HALT : ST_T0;
                end else begin
                    state_d = state_t'(state_q + 4'd1);
                end
            end
        endcase
    end

    ctrl_decode u_ctrl_decode (
        .state  (state_q),
        .opcode (opcode),
        .conFF  (conFF),
        .ctrl   (ctrl)
    );

    assign run  = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign step = state_q;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Randomised self-checking bench for control_unit against a
//            per-instruction step-list reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

    localparam logic [29:0] PCOUT  = 30'd1 << 0;
    localparam logic [29:0] ZHI    = 30'd1 << 1;
    localparam logic [29:0] ZLO    = 30'd1 << 2;
    localparam logic [29:0] MDROUT = 30'd1 << 3;
    localparam logic [29:0] HIOUT  = 30'd1 << 4;
    localparam logic [29:0] LOOUT  = 30'd1 << 5;
    localparam logic [29:0] INPOUT = 30'd1 << 6;
    localparam logic [29:0] COUT   = 30'd1 << 7;
    localparam logic [29:0] MARIN  = 30'd1 << 9;
    localparam logic [29:0] MDRIN  = 30'd1 << 10;
    localparam logic [29:0] PCIN   = 30'd1 << 11;
    localparam logic [29:0] IRIN   = 30'd1 << 12;
    localparam logic [29:0] YIN    = 30'd1 << 13;
    localparam logic [29:0] ZIN    = 30'd1 << 14;
    localparam logic [29:0] HIIN   = 30'd1 << 15;
    localparam logic [29:0] LOIN   = 30'd1 << 16;
    localparam logic [29:0] INCPC  = 30'd1 << 17;
    localparam logic [29:0] READ   = 30'd1 << 18;
    localparam logic [29:0] RAMRD  = 30'd1 << 19;
    localparam logic [29:0] RAMIN  = 30'd1 << 20;
    localparam logic [29:0] GRA    = 30'd1 << 21;
    localparam logic [29:0] GRB    = 30'd1 << 22;
    localparam logic [29:0] GRC    = 30'd1 << 23;
    localparam logic [29:0] BAOUT  = 30'd1 << 24;
    localparam logic [29:0] ROUT   = 30'd1 << 25;
    localparam logic [29:0] REN    = 30'd1 << 26;
    localparam logic [29:0] ENCON  = 30'd1 << 27;
    localparam logic [29:0] ENOUT  = 30'd1 << 28;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  opcode;
    logic        conFF;
    logic [29:0] ctrl;
    logic        run;
    logic [3:0]  step;
`ifdef CU_STOP_EN
    logic        stop;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [29:0] exp_q[$];

    always #5 clk = ~clk;

    control_unit dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .conFF  (conFF),
`ifdef CU_STOP_EN
        .stop   (stop),
`endif
        .ctrl   (ctrl),
        .run    (run),
        .step   (step)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the full list of control words an instruction emits, one per cycle.
    task automatic build_expect(input logic [4:0] op, input logic cff);
        exp_q = {};
        exp_q.push_back(PCOUT | MARIN | INCPC);
        exp_q.push_back(RAMRD | READ | MDRIN);
        exp_q.push_back(MDROUT | IRIN);
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                exp_q.push_back(GRB | ROUT | YIN);
                exp_q.push_back(GRC | ROUT | ZIN);
                exp_q.push_back(ZLO | GRA | REN);
            end
            5'd12, 5'd13, 5'd14: begin
                exp_q.push_back(GRB | ROUT | YIN);
                exp_q.push_back(COUT | ZIN);
                exp_q.push_back(ZLO | GRA | REN);
            end
            5'd15, 5'd16: begin
                exp_q.push_back(GRA | ROUT | YIN);
                exp_q.push_back(GRB | ROUT | ZIN);
                exp_q.push_back(ZLO | LOIN);
                exp_q.push_back(ZHI | HIIN);
            end
            5'd17, 5'd19: begin
                exp_q.push_back(GRB | ROUT | ZIN);
                exp_q.push_back(ZLO | GRA | REN);
            end
            5'd1: begin
                exp_q.push_back(GRB | BAOUT | YIN);
                exp_q.push_back(COUT | ZIN);
                exp_q.push_back(ZLO | GRA | REN);
            end
            5'd0: begin
                exp_q.push_back(GRB | BAOUT | YIN);
                exp_q.push_back(COUT | ZIN);
                exp_q.push_back(ZLO | MARIN);
                exp_q.push_back(RAMRD | READ | MDRIN);
                exp_q.push_back(MDROUT | GRA | REN);
            end
            5'd2: begin
                exp_q.push_back(GRB | BAOUT | YIN);
                exp_q.push_back(COUT | ZIN);
                exp_q.push_back(ZLO | MARIN);
                exp_q.push_back(GRA | ROUT | MDRIN);
                exp_q.push_back(RAMIN);
            end
            5'd18: begin
                exp_q.push_back(GRA | ROUT | ENCON);
                exp_q.push_back(PCOUT | YIN);
                exp_q.push_back(COUT | ZIN);
                exp_q.push_back(ZLO | (cff ? PCIN : 30'd0));
            end
            5'd20: exp_q.push_back(GRA | ROUT | PCIN);
            5'd21: exp_q.push_back(GRA | REN | INPOUT);
            5'd22: exp_q.push_back(GRA | ROUT | ENOUT);
            5'd23: exp_q.push_back(GRA | REN | LOOUT);
            5'd24: exp_q.push_back(GRA | REN | HIOUT);
            default: ;
        endcase
    endtask

    // Entered and left sampled #1 after a rising edge; state must be T0 on entry.
    task automatic run_instr(input logic [4:0] op, input logic cff, input logic stop_last, input string name);
        opcode = op;
        conFF  = cff;
        build_expect(op, cff);
        for (int k = 0; k < exp_q.size(); k++) begin
`ifdef CU_STOP_EN
            stop = stop_last && (k == exp_q.size() - 1);
`else
            if (stop_last) $display("note: stop requested without CU_STOP_EN (%s)", name);
`endif
            check_val({name, " step"}, {28'd0, step}, k + 1);
            check_val({name, " ctrl"}, {2'd0, ctrl}, {2'd0, exp_q[k]});
            check_val({name, " run"},  {31'd0, run}, 32'd1);
            @(posedge clk); #1;
        end
`ifdef CU_STOP_EN
        stop = 1'b0;
`endif
    endtask

    task automatic check_idle_then_t0(input string name);
        check_val({name, " rst step"}, {28'd0, step}, 32'd0);
        check_val({name, " rst ctrl"}, {2'd0, ctrl}, 32'd0);
        check_val({name, " rst run"},  {31'd0, run}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val({name, " first T0"}, {28'd0, step}, 32'd1);
    endtask

    initial begin
        logic [4:0] op;
        rst = 1'b1; opcode = 5'd0; conFF = 1'b0;
`ifdef CU_STOP_EN
        stop = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_idle_then_t0("reset");

        run_instr(5'b00011, 1'b0, 1'b0, "add");
        run_instr(5'b10010, 1'b1, 1'b0, "br_taken");
        run_instr(5'b10010, 1'b0, 1'b0, "br_not");
        run_instr(5'b00010, 1'b0, 1'b0, "st");
        run_instr(5'b11111, 1'b0, 1'b0, "undef");
        run_instr(5'b11001, 1'b1, 1'b0, "nop");
        run_instr(5'b00000, 1'b0, 1'b0, "ld");

        for (int i = 0; i < 40; i++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11010) op = 5'b11001;
            run_instr(op, 1'($urandom_range(0, 1)), 1'b0, $sformatf("rnd%0d_op%0d", i, op));
        end
        check_val("post_rnd T0", {28'd0, step}, 32'd1);

        // Abort add in T5 with an asynchronous reset pulse.
        opcode = 5'b00011;
        repeat (5) begin @(posedge clk); #1; end
        check_val("add_mid T5", {28'd0, step}, 32'd6);
        #2 rst = 1'b1;
        #1;
        check_idle_then_t0("mid_reset");

        run_instr(5'b11010, 1'b0, 1'b0, "halt");
        for (int i = 0; i < 20; i++) begin
            check_val("halt step", {28'd0, step}, 32'd9);
            check_val("halt run",  {31'd0, run}, 32'd0);
            check_val("halt ctrl", {2'd0, ctrl}, 32'd0);
            opcode = 5'($urandom_range(0, 31));
            @(posedge clk); #1;
        end

`ifdef CU_STOP_EN
        rst = 1'b1;
        #1;
        check_idle_then_t0("stop_reset");
        run_instr(5'b10000, 1'b0, 1'b1, "mul_stop");
        check_val("mul_stop halt", {28'd0, step}, 32'd9);
        check_val("mul_stop run",  {31'd0, run}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
